pipe_hazard_ctrl: RTL and testbench

- Parametrised pipeline control unit for the ARM core.
- Replaces the constant `hazard`, `freeze` and `flush` tie-offs at the core top with real control.
- Keeps a scoreboard shift chain of in-flight destination registers for the stages after ID (EXE, MEM, WB, ...).
- Detects RAW hazards for the instruction in ID and drives freeze/flush to IF/ID.
- Optional forwarding mode, where only load-use stalls are raised, plus saturating stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 98 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: in-flight dest scoreboard, RAW detection,
// freeze/flush generation and saturating stall/flush counters.
module pipe_hazard_ctrl #(
   parameter int REG_W  = 4,
   parameter int DEPTH  = 3,
   parameter int FWD_EN = 0,
   parameter int CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic [REG_W-1:0]       id_src1,
   input  logic [REG_W-1:0]       id_src2,
   input  logic                   id_two_src,
   input  logic                   id_wb_en,
   input  logic                   id_mem_r_en,
   input  logic [REG_W-1:0]       id_dest,
   input  logic                   br_taken,
   input  logic                   ext_freeze,
   output logic                   hazard,
   output logic                   freeze,
   output logic                   flush,
   output logic [DEPTH-1:0]       stage_valid,
   output logic [DEPTH*REG_W-1:0] stage_dest,
   output logic [CNT_W-1:0]       stall_cnt,
   output logic [CNT_W-1:0]       flush_cnt
);

   typedef struct packed {
      logic             v;
      logic             wb;
      logic             mr;
      logic [REG_W-1:0] d;
   } ent_t;

   ent_t sb_q [DEPTH];
   ent_t ent_in;
   logic m1;
   logic m2;

   // With forwarding, only a load sitting in EXE can still stall ID
   always_comb begin
      m1 = 1'b0;
      m2 = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (sb_q[k].v && sb_q[k].wb &&
             (FWD_EN == 0 || (k == 0 && sb_q[k].mr))) begin
            if (sb_q[k].d == id_src1) m1 = 1'b1;
            if (sb_q[k].d == id_src2) m2 = 1'b1;
         end
      end
   end

   assign hazard = id_valid & ~br_taken & (m1 | (id_two_src & m2));
   assign flush  = br_taken;
   assign freeze = hazard | ext_freeze;

   always_comb begin
      ent_in = '0;
      if (!(hazard || br_taken)) begin
         ent_in.v  = id_valid;
         ent_in.wb = id_wb_en & id_valid;
         ent_in.mr = id_mem_r_en & id_valid;
         ent_in.d  = id_dest;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++) sb_q[k] <= '0;
      end else if (!ext_freeze) begin
         sb_q[0] <= ent_in;
         for (int k = 1; k < DEPTH; k++) sb_q[k] <= sb_q[k-1];
      end
   end

   always_comb begin
      stage_valid = '0;
      stage_dest  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         stage_valid[k]               = sb_q[k].v;
         stage_dest[k*REG_W +: REG_W] = sb_q[k].d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (hazard && !ext_freeze && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if (flush && flush_cnt != '1)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed scoreboard bench for pipe_hazard_ctrl,
// one instance without and one with forwarding.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_two_src, id_wb_en, id_mem_r_en;
   logic [3:0]  id_src1, id_src2, id_dest;
   logic        br_taken, ext_freeze;
   logic        hz0, fz0, fl0, hz1, fz1, fl1;
   logic [2:0]  sv0, sv1;
   logic [11:0] sd0, sd1;
   logic [3:0]  sc0, fc0, sc1, fc1;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_W(4), .DEPTH(3), .FWD_EN(0), .CNT_W(4)) d0 (
      .clk(clk), .rst(rst_n), .id_valid(id_valid), .id_src1(id_src1),
      .id_src2(id_src2), .id_two_src(id_two_src), .id_wb_en(id_wb_en),
      .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .br_taken(br_taken),
      .ext_freeze(ext_freeze), .hazard(hz0), .freeze(fz0), .flush(fl0),
      .stage_valid(sv0), .stage_dest(sd0), .stall_cnt(sc0), .flush_cnt(fc0)
   );

   pipe_hazard_ctrl #(.REG_W(4), .DEPTH(3), .FWD_EN(1), .CNT_W(4)) d1 (
      .clk(clk), .rst(rst_n), .id_valid(id_valid), .id_src1(id_src1),
      .id_src2(id_src2), .id_two_src(id_two_src), .id_wb_en(id_wb_en),
      .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .br_taken(br_taken),
      .ext_freeze(ext_freeze), .hazard(hz1), .freeze(fz1), .flush(fl1),
      .stage_valid(sv1), .stage_dest(sd1), .stall_cnt(sc1), .flush_cnt(fc1)
   );

   typedef struct packed {
      bit       v;
      bit       wb;
      bit       mr;
      bit [3:0] d;
   } rec_t;

   typedef struct {
      bit        hz, fz, fl;
      bit [2:0]  sv;
      bit [11:0] sd;
      bit [3:0]  sc, fc;
   } exp_t;

   rec_t ch0[$], ch1[$];
   exp_t q0[$], q1[$];
   int   msc0, mfc0, msc1, mfc1;
   int   n_chk = 0, n_pass = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   function automatic bit mhaz(input rec_t ch[$], input bit fwd, input bit v,
                               input bit br, input bit two,
                               input bit [3:0] s1, input bit [3:0] s2);
      bit h = 1'b0;
      if (!v || br) return 1'b0;
      foreach (ch[k]) begin
         if (!(ch[k].v && ch[k].wb)) continue;
         if (fwd && (k != 0 || !ch[k].mr)) continue;
         if (ch[k].d == s1 || (two && ch[k].d == s2)) h = 1'b1;
      end
      return h;
   endfunction

   function automatic exp_t mk(input rec_t ch[$], input bit h, input bit br,
                               input bit ef, input int sc, input int fc);
      exp_t e;
      e.hz = h;
      e.fz = h | ef;
      e.fl = br;
      e.sv = '0;
      e.sd = '0;
      for (int k = 0; k < 3; k++) begin
         e.sv[k]        = ch[k].v;
         e.sd[k*4 +: 4] = ch[k].d;
      end
      e.sc = 4'(sc);
      e.fc = 4'(fc);
      return e;
   endfunction

   function automatic int sat(input int c);
      return (c < 15) ? c + 1 : 15;
   endfunction

   task automatic model_reset();
      ch0.delete();
      ch1.delete();
      repeat (3) begin
         ch0.push_back('0);
         ch1.push_back('0);
      end
      msc0 = 0; mfc0 = 0; msc1 = 0; mfc1 = 0;
   endtask

   task automatic step(bit r, bit v, int s1, int s2, bit two, bit wb,
                       bit mr, int d, bit br, bit ef);
      bit   h0, h1;
      rec_t n;
      @(negedge clk);
      rst_n       = r;
      id_valid    = v;
      id_src1     = 4'(s1);
      id_src2     = 4'(s2);
      id_two_src  = two;
      id_wb_en    = wb;
      id_mem_r_en = mr;
      id_dest     = 4'(d);
      br_taken    = br;
      ext_freeze  = ef;
      if (!r) model_reset();
      h0 = mhaz(ch0, 1'b0, v, br, two, 4'(s1), 4'(s2));
      h1 = mhaz(ch1, 1'b1, v, br, two, 4'(s1), 4'(s2));
      q0.push_back(mk(ch0, h0, br, ef, msc0, mfc0));
      q1.push_back(mk(ch1, h1, br, ef, msc1, mfc1));
      if (r) begin
         if (h0 && !ef) msc0 = sat(msc0);
         if (h1 && !ef) msc1 = sat(msc1);
         if (br) begin
            mfc0 = sat(mfc0);
            mfc1 = sat(mfc1);
         end
         if (!ef) begin
            n = '{v: v, wb: wb & v, mr: mr & v, d: 4'(d)};
            ch0.push_front((h0 || br) ? rec_t'(0) : n);
            ch1.push_front((h1 || br) ? rec_t'(0) : n);
            void'(ch0.pop_back());
            void'(ch1.pop_back());
         end
      end
   endtask

   // Monitor: pops one expectation per DUT each cycle and compares
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("d0.hazard", 32'(hz0), 32'(e.hz));
            chk("d0.freeze", 32'(fz0), 32'(e.fz));
            chk("d0.flush", 32'(fl0), 32'(e.fl));
            chk("d0.stage_valid", 32'(sv0), 32'(e.sv));
            chk("d0.stage_dest", 32'(sd0), 32'(e.sd));
            chk("d0.stall_cnt", 32'(sc0), 32'(e.sc));
            chk("d0.flush_cnt", 32'(fc0), 32'(e.fc));
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("d1.hazard", 32'(hz1), 32'(e.hz));
            chk("d1.freeze", 32'(fz1), 32'(e.fz));
            chk("d1.flush", 32'(fl1), 32'(e.fl));
            chk("d1.stage_valid", 32'(sv1), 32'(e.sv));
            chk("d1.stage_dest", 32'(sd1), 32'(e.sd));
            chk("d1.stall_cnt", 32'(sc1), 32'(e.sc));
            chk("d1.flush_cnt", 32'(fc1), 32'(e.fc));
         end
      end
   end

   task automatic do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 3, 3, 1, 1, 0, 3, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rnd_run(int n);
      for (int i = 0; i < n; i++)
         step(1, ($urandom % 4) != 0, $urandom % 4, $urandom % 4,
              $urandom % 2, ($urandom % 4) != 0, ($urandom % 3) == 0,
              $urandom % 4, ($urandom % 10) == 0, ($urandom % 8) == 0);
   endtask

   initial begin
      rst_n = 1'b0;
      id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
      id_wb_en = 0; id_mem_r_en = 0; id_dest = 0;
      br_taken = 0; ext_freeze = 0;
      model_reset();
      do_reset();

      // ADD r3 then dependent read: 3-cycle stall without forwarding
      step(1, 1, 0, 0, 0, 1, 0, 3, 0, 0);
      repeat (4) step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);

      // LDR r5 then src2 read: single load-use stall with forwarding
      step(1, 1, 0, 0, 0, 1, 1, 5, 0, 0);
      repeat (4) step(1, 1, 1, 5, 1, 0, 0, 0, 0, 0);

      // pending hazard killed by a taken branch
      step(1, 1, 0, 0, 0, 1, 1, 7, 0, 0);
      step(1, 1, 7, 0, 0, 0, 0, 0, 1, 0);
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);

      // ext_freeze holds the chain with a writer in EXE
      do_reset();
      step(1, 1, 0, 0, 0, 1, 1, 9, 0, 0);
      repeat (4) step(1, 1, 9, 9, 1, 0, 0, 0, 0, 1);
      step(1, 1, 9, 0, 0, 0, 0, 0, 1, 1);
      repeat (4) step(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);

      // stall counter saturation
      do_reset();
      repeat (7) begin
         step(1, 1, 0, 0, 0, 1, 0, 3, 0, 0);
         repeat (4) step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      end
      repeat (20) step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);

      // random traffic with an asynchronous reset in the middle
      rnd_run(300);
      do_reset();
      rnd_run(300);

      repeat (3) @(negedge clk);
      n_chk++;
      if (q0.size() == 0 && q1.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d/%0d pending expected 0", q0.size(), q1.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
